pc_sequencer: RTL and testbench

Fetch-side controller that owns the 32-bit program counter and sequences its updates. It selects among sequential, jump and conditional-branch next addresses. It freezes the PC while either cache asserts busywait, and buffers the pending next-PC so that decoder outputs may change during a stall. It sits between the control unit/ALU (BRANCH, ZERO, OFFSET), the instruction and data caches (busywait), and the instruction memory address port.

---
 rtl/pc_sequencer.sv | 117 +++++++++++
 tb/tb_pc_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-side program-counter sequencer: selects sequential/jump/branch next PC,
// freezes the PC while either cache is busy and replays the buffered target afterwards.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       BRANCH,
    input  logic             ZERO,
    input  logic [7:0]       OFFSET,
    input  logic             IBUSY,
    input  logic             DBUSY,
    input  logic             HALT,
    output logic [31:0]      PC,
    output logic             FETCH_VALID,
    output logic             STALL,
    output logic [CNT_W-1:0] STALL_COUNT
);

    localparam logic [1:0] S_BOOT   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pend_q, pend_d;
    logic             fv_q, fv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             busy;
    logic             take;
    logic [31:0]      seq_pc;
    logic [31:0]      tgt_pc;
    logic [31:0]      npc;

    // Word offset to byte offset, sign preserved.
    function automatic logic [31:0] byte_offset(input logic [7:0] off);
        logic signed [31:0] ext;
        ext = {{24{off[7]}}, off};
        return ext <<< 2;
    endfunction

    // Stall counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign busy   = IBUSY | DBUSY;
    assign seq_pc = pc_q + 32'd4;
    assign tgt_pc = seq_pc + byte_offset(OFFSET);
    assign take   = BRANCH[0] ^ (BRANCH[1] & ZERO);
    assign npc    = take ? tgt_pc : seq_pc;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        fv_d    = fv_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
                fv_d    = 1'b1;
            end
            S_RUN: begin
                if (busy) begin
                    // Capture the target now: decoder outputs may change while stalled.
                    pend_d  = npc;
                    cnt_d   = sat_inc(cnt_q);
                    state_d = S_WAIT;
                end else if (HALT) begin
                    fv_d    = 1'b0;
                    state_d = S_HALTED;
                end else begin
                    pc_d = npc;
                end
            end
            S_WAIT: begin
                if (busy) begin
                    cnt_d = sat_inc(cnt_q);
                end else begin
                    pc_d    = pend_q;
                    state_d = S_RUN;
                end
            end
            S_HALTED: begin
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= 32'd0;
            fv_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            fv_q    <= fv_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PC          = pc_q;
    assign FETCH_VALID = fv_q;
    assign STALL       = busy & ((state_q == S_RUN) | (state_q == S_WAIT));
    assign STALL_COUNT = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a second instance (CNT_W=4, PC near the top of
// the address space) shares the stimulus to cover PC wrap and counter saturation.
module tb_pc_sequencer;

    logic        CLK;
    logic        RESET;
    logic [1:0]  BRANCH;
    logic        ZERO;
    logic [7:0]  OFFSET;
    logic        IBUSY;
    logic        DBUSY;
    logic        HALT;

    logic [31:0] pc1;
    logic        fv1;
    logic        stall1;
    logic [15:0] cnt1;

    logic [31:0] pc2;
    logic        fv2;
    logic        stall2;
    logic [3:0]  cnt2;

    int n_checks;
    int n_fail;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(16)) u_main (
        .CLK(CLK), .RESET(RESET), .BRANCH(BRANCH), .ZERO(ZERO), .OFFSET(OFFSET),
        .IBUSY(IBUSY), .DBUSY(DBUSY), .HALT(HALT),
        .PC(pc1), .FETCH_VALID(fv1), .STALL(stall1), .STALL_COUNT(cnt1)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(4)) u_small (
        .CLK(CLK), .RESET(RESET), .BRANCH(BRANCH), .ZERO(ZERO), .OFFSET(OFFSET),
        .IBUSY(IBUSY), .DBUSY(DBUSY), .HALT(HALT),
        .PC(pc2), .FETCH_VALID(fv2), .STALL(stall2), .STALL_COUNT(cnt2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] br, input logic z, input logic [7:0] off);
        BRANCH = br;
        ZERO   = z;
        OFFSET = off;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RESET = 1'b1;
        drive(2'b00, 1'b0, 8'h00);
        IBUSY = 1'b0;
        DBUSY = 1'b0;
        HALT  = 1'b0;

        // Reset and boot
        step();
        step();
        chk("rst_pc", pc1, 32'h0);
        chk("rst_fv", {31'd0, fv1}, 32'd0);
        chk("rst_cnt", {16'd0, cnt1}, 32'd0);
        chk("rst_pc_small", pc2, 32'hFFFF_FFF8);
        RESET = 1'b0;
        IBUSY = 1'b1;
        #1;
        chk("boot_stall", {31'd0, stall1}, 32'd0);
        IBUSY = 1'b0;
        step();
        chk("boot_pc", pc1, 32'h0);
        chk("boot_fv", {31'd0, fv1}, 32'd1);
        chk("boot_fv_small", {31'd0, fv2}, 32'd1);
        step();
        chk("seq_pc4", pc1, 32'h4);
        chk("seq_small_fc", pc2, 32'hFFFF_FFFC);
        step();
        chk("seq_pc8", pc1, 32'h8);
        chk("wrap_small", pc2, 32'h0);

        // Branch types around 0x20
        drive(2'b01, 1'b0, 8'h05); step(); chk("jmp_to_20", pc1, 32'h20);
        drive(2'b10, 1'b1, 8'h03); step(); chk("beq_taken", pc1, 32'h30);
        drive(2'b01, 1'b0, 8'hFB); step(); chk("jmp_back_20", pc1, 32'h20);
        drive(2'b10, 1'b0, 8'h03); step(); chk("beq_not_taken", pc1, 32'h24);
        drive(2'b01, 1'b0, 8'hFE); step(); chk("jmp_neg_20", pc1, 32'h20);
        drive(2'b11, 1'b0, 8'hFE); step(); chk("bne_taken", pc1, 32'h1C);
        drive(2'b01, 1'b0, 8'h00); step(); chk("jmp_zero_off", pc1, 32'h20);
        drive(2'b01, 1'b0, 8'hFF); step(); chk("self_loop", pc1, 32'h20);
        drive(2'b11, 1'b1, 8'hFE); step(); chk("bne_not_taken", pc1, 32'h24);
        drive(2'b01, 1'b0, 8'h06); step(); chk("jmp_to_40", pc1, 32'h40);

        // Stall buffering: target captured on first busy edge
        drive(2'b10, 1'b1, 8'h02);
        IBUSY = 1'b1;
        #1;
        chk("run_stall", {31'd0, stall1}, 32'd1);
        step();
        drive(2'b00, 1'b0, 8'h00);
        chk("stall1_pc", pc1, 32'h40);
        step();
        step();
        chk("stall3_pc", pc1, 32'h40);
        chk("stall3_sig", {31'd0, stall1}, 32'd1);
        chk("stall3_cnt", {16'd0, cnt1}, 32'd3);
        IBUSY = 1'b0;
        #1;
        chk("wait_nobusy_stall", {31'd0, stall1}, 32'd0);
        step();
        chk("resume_pend", pc1, 32'h4C);
        chk("resume_cnt", {16'd0, cnt1}, 32'd3);

        // Busy outranks halt; halt in WAIT is dropped
        DBUSY = 1'b1;
        HALT  = 1'b1;
        step();
        chk("busy_halt_pc", pc1, 32'h4C);
        chk("busy_halt_fv", {31'd0, fv1}, 32'd1);
        DBUSY = 1'b0;
        step();
        chk("after_wait_pc", pc1, 32'h50);
        chk("after_wait_fv", {31'd0, fv1}, 32'd1);
        step();
        chk("halted_fv", {31'd0, fv1}, 32'd0);
        chk("halted_pc", pc1, 32'h50);
        HALT = 1'b0;
        drive(2'b01, 1'b0, 8'h10);
        IBUSY = 1'b1;
        #1;
        chk("halted_stall", {31'd0, stall1}, 32'd0);
        step();
        chk("halted_frozen_pc", pc1, 32'h50);
        chk("halted_frozen_fv", {31'd0, fv1}, 32'd0);
        IBUSY = 1'b0;

        // Reset mid-stall discards the pending target
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        drive(2'b00, 1'b0, 8'h00);
        step();
        chk("reboot_pc", pc1, 32'h0);
        drive(2'b01, 1'b0, 8'h10);
        IBUSY = 1'b1;
        step();
        chk("wait_before_rst_pc", pc1, 32'h0);
        chk("wait_before_rst_cnt", {16'd0, cnt1}, 32'd1);
        RESET = 1'b1;
        step();
        chk("midstall_rst_pc", pc1, 32'h0);
        chk("midstall_rst_fv", {31'd0, fv1}, 32'd0);
        chk("midstall_rst_cnt", {16'd0, cnt1}, 32'd0);
        RESET = 1'b0;
        IBUSY = 1'b0;
        drive(2'b00, 1'b0, 8'h00);
        step();
        chk("post_rst_boot_pc", pc1, 32'h0);
        step();
        chk("no_stale_target", pc1, 32'h4);

        // Long stall: 16-bit counter keeps counting, 4-bit one saturates
        IBUSY = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("long_stall_pc", pc1, 32'h4);
        chk("long_stall_cnt", {16'd0, cnt1}, 32'd20);
        chk("sat_cnt_small", {28'd0, cnt2}, 32'd15);
        chk("sat_stall_small", {31'd0, stall2}, 32'd1);
        IBUSY = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
